// File: rtl/life_host_ctrl.sv
// life_host_ctrl: host-side controller for the 8x8 Game of Life grid.
// Loads an 8-byte seed over a valid/ready stream and presents it to the grid
// on `seeds` while holding `grid_rst`. It then lets the grid evolve for GENS
// generations, captures `cells`, and streams the snapshot back as 8 row bytes.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : seed byte handshake (in_ready high only in LOAD)
//   in_data[7:0]        : seed row byte; byte k is row k, bit c is column c
//   seeds[63:0]         : registered seed bus to grid (bit r*8+c)
//   grid_rst            : registered active-high grid reset (grid holds seeds)
//   cells[63:0]         : current grid state from the grid
//   out_valid/out_ready : result byte handshake (out_valid high only in SEND)
//   out_data[7:0]       : snapshot row row_idx
//   out_last            : marks row 7
//   busy                : high in PRIME, RUN and SEND
module life_host_ctrl #(
  parameter int unsigned GENS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [63:0] seeds,
  output logic        grid_rst,
  input  logic [63:0] cells,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned CW = (GENS == 0) ? 1 : $clog2(GENS + 1);
  localparam int unsigned RW = 3;
  localparam int unsigned BW = 8;
  localparam int unsigned GW = 64;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [RW-1:0]   row_idx, row_idx_d, row_nxt;
  logic [CW-1:0]   gen_cnt, gen_cnt_d;
  logic [GW-1:0]   seeds_d;
  logic [GW-1:0]   snap, snap_d;
  logic            grid_rst_d;
  logic            in_ready_d;
  logic            out_valid_d;
  logic            out_last_d;
  logic            busy_d;
  logic [BW-1:0]   out_data_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      row_idx   <= '0;
      gen_cnt   <= '0;
      seeds     <= '0;
      snap      <= '0;
      grid_rst  <= 1'b1;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      row_idx   <= row_idx_d;
      gen_cnt   <= gen_cnt_d;
      seeds     <= seeds_d;
      snap      <= snap_d;
      grid_rst  <= grid_rst_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d    = state;
    row_idx_d  = row_idx;
    gen_cnt_d  = gen_cnt;
    seeds_d    = seeds;
    snap_d     = snap;
    grid_rst_d = grid_rst;
    out_data_d = out_data;
    out_last_d = out_last;
    row_nxt    = row_idx + RW'(1);

    case (state)
      S_LOAD: begin
        // in_ready is registered high for the whole of LOAD
        if (in_valid) begin
          seeds_d[{row_idx, 3'b000} +: BW] = in_data;
          if (row_idx == RW'(7)) begin
            row_idx_d = '0;
            state_d   = S_PRIME;
          end else begin
            row_idx_d = row_nxt;
          end
        end
      end

      S_PRIME: begin
        // grid has seen the complete seed under reset for one edge
        grid_rst_d = 1'b0;
        gen_cnt_d  = '0;
        state_d    = S_RUN;
      end

      S_RUN: begin
        if (gen_cnt != CW'(GENS)) begin
          gen_cnt_d = gen_cnt + CW'(1);
        end else begin
          // pre-edge cells hold generation GENS; the grid's extra step is
          // wiped by its reset rising on this same edge
          snap_d     = cells;
          grid_rst_d = 1'b1;
          out_data_d = cells[BW-1:0];
          out_last_d = 1'b0;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        if (out_ready) begin
          if (row_idx == RW'(7)) begin
            row_idx_d  = '0;
            out_data_d = '0;
            out_last_d = 1'b0;
            state_d    = S_LOAD;
          end else begin
            row_idx_d  = row_nxt;
            out_data_d = snap[{row_nxt, 3'b000} +: BW];
            out_last_d = (row_nxt == RW'(7));
          end
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase

    // Handshake/status outputs follow the next state so they stay registered
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_SEND);
    busy_d      = (state_d != S_LOAD);
  end

endmodule

// File: tb/tb_life_host_ctrl.sv
// tb_life_host_ctrl: self-checking bench for life_host_ctrl.
// Four controller+grid pairs with GENS = 0, 1, 5, 16. Each grid is a
// behavioural Game of Life model with an empty border; expected output is the
// seed evolved GENS times by plain arithmetic on a 2-D neighbourhood count.
module tb_life_host_ctrl;

  localparam int NI = 4;

  logic          clk;
  logic          rst;
  logic [NI-1:0] in_valid;
  logic [NI-1:0] in_ready;
  logic [NI-1:0] grid_rst_v;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_ready;
  logic [NI-1:0] out_last;
  logic [NI-1:0] busy;
  logic [7:0]    in_data  [NI];
  logic [7:0]    out_data [NI];
  logic [63:0]   seeds_v  [NI];

  int checks;
  int failures;

  function automatic int gens_of(int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 5;
      default: return 16;
    endcase
  endfunction

  // One Game of Life step on an 8x8 board, cells outside are dead
  function automatic logic [63:0] life_step(logic [63:0] s);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < 8) &&
                (c + dc >= 0) && (c + dc < 8)) begin
              if (s[(r + dr) * 8 + (c + dc)]) cnt++;
            end
          end
        end
        n[r * 8 + c] = (cnt == 3) || (s[r * 8 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] life_n(logic [63:0] s, int n);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = life_step(t);
    return t;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_pair
      localparam int unsigned GG = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 5 : 16;
      logic [63:0] seeds_l;
      logic [63:0] cells_l;
      logic        grid_rst_l;

      life_host_ctrl #(.GENS(GG)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data[g]),
        .seeds     (seeds_l),
        .grid_rst  (grid_rst_l),
        .cells     (cells_l),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g]),
        .out_last  (out_last[g]),
        .busy      (busy[g])
      );

      // Grid model: holds seeds while in reset, else one generation per edge
      always @(posedge clk or posedge grid_rst_l) begin
        if (grid_rst_l) cells_l <= seeds_l;
        else            cells_l <= life_step(cells_l);
      end

      assign grid_rst_v[g] = grid_rst_l;
      assign seeds_v[g]    = seeds_l;
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int idx, input string tag);
    check({tag, "_in_ready"},  64'(in_ready[idx]),   64'd1);
    check({tag, "_out_valid"}, 64'(out_valid[idx]),  64'd0);
    check({tag, "_busy"},      64'(busy[idx]),       64'd0);
    check({tag, "_grid_rst"},  64'(grid_rst_v[idx]), 64'd1);
    check({tag, "_out_last"},  64'(out_last[idx]),   64'd0);
  endtask

  // Push 8 seed bytes; gappy inserts random in_valid bubbles
  task automatic load_seed(input int idx, input logic [63:0] seed, input bit gappy);
    int k;
    int guard;
    bit hs;
    k = 0;
    guard = 0;
    while (k < 8 && guard < 200) begin
      in_data[idx]  = seed[k * 8 +: 8];
      in_valid[idx] = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
      hs = in_valid[idx] && in_ready[idx];
      step();
      if (hs) k++;
      guard++;
    end
    check("load_bytes", 64'(k), 64'd8);
    in_valid[idx] = 1'b0;
    in_data[idx]  = 8'($urandom);
    check("seeds_loaded", seeds_v[idx], seed);
  endtask

  // Wait for out_valid after the 8th seed handshake, timing and ignoring junk
  task automatic wait_result(input int idx, input logic [63:0] seed);
    int edges;
    int lows;
    edges = 0;
    lows  = 0;
    while (edges < 100) begin
      in_valid[idx]  = 1'($urandom);
      in_data[idx]   = 8'($urandom);
      out_ready[idx] = 1'($urandom);
      step();
      edges++;
      if (!grid_rst_v[idx]) lows++;
      if (out_valid[idx]) break;
      check("run_in_ready", 64'(in_ready[idx]), 64'd0);
      check("run_busy",     64'(busy[idx]),     64'd1);
    end
    out_ready[idx] = 1'b0;
    check("latency",       64'(edges), 64'(gens_of(idx) + 2));
    check("grid_rst_low",  64'(lows),  64'(gens_of(idx) + 1));
    check("send_grid_rst", 64'(grid_rst_v[idx]), 64'd1);
    check("seeds_hold",    seeds_v[idx], seed);
  endtask

  // Take nrows result bytes; omode 0 full rate, 1 random, 2 pattern 1,0,0
  task automatic recv(input int idx, input logic [63:0] exp, input int nrows, input int omode);
    int k;
    int phase;
    int guard;
    bit hs;
    k = 0;
    phase = 0;
    guard = 0;
    while (k < nrows && guard < 200) begin
      check("out_valid", 64'(out_valid[idx]), 64'd1);
      check("out_data",  64'(out_data[idx]),  64'(exp[k * 8 +: 8]));
      check("out_last",  64'(out_last[idx]),  64'(k == 7));
      check("send_busy", 64'(busy[idx]),      64'd1);
      check("send_in_ready", 64'(in_ready[idx]), 64'd0);
      case (omode)
        0:       out_ready[idx] = 1'b1;
        1:       out_ready[idx] = 1'($urandom);
        default: out_ready[idx] = (phase % 3 == 0);
      endcase
      phase++;
      in_valid[idx] = 1'($urandom);
      in_data[idx]  = 8'($urandom);
      hs = out_ready[idx];
      step();
      if (hs) k++;
      guard++;
    end
    check("recv_rows", 64'(k), 64'(nrows));
    out_ready[idx] = 1'b0;
    in_valid[idx]  = 1'b0;
    if (nrows == 8) check_idle(idx, "post_frame");
  endtask

  task automatic run_frame(input int idx, input logic [63:0] seed, input logic [63:0] exp,
                           input bit gappy, input int omode);
    load_seed(idx, seed, gappy);
    wait_result(idx, seed);
    recv(idx, exp, 8, omode);
  endtask

  // Asynchronous reset pulse placed mid-cycle
  task automatic pulse_rst(input int idx, input string tag);
    #3 rst = 1'b1;
    #1;
    check_idle(idx, tag);
    check({tag, "_seeds"}, seeds_v[idx], 64'd0);
    #2 rst = 1'b0;
    step();
  endtask

  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] SEED_A  = 64'h1824_4281_00FF_5AA5;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

  initial begin
    logic [63:0] seed;
    int idx;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < NI; i++) in_data[i] = 8'h00;
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      check_idle(i, "reset");
      check("reset_seeds",    seeds_v[i],        64'd0);
      check("reset_out_data", 64'(out_data[i]),  64'd0);
    end
    rst = 1'b0;
    step();

    // Directed frames with hand-derived results
    run_frame(1, BLINK_V, BLINK_H, 1'b0, 0);
    run_frame(0, SEED_A,  SEED_A,  1'b0, 0);
    run_frame(3, BLOCK,   BLOCK,   1'b1, 1);
    run_frame(2, BLINK_V, BLINK_H, 1'b0, 0);
    run_frame(1, SEED_A,  life_n(SEED_A, 1), 1'b1, 2);

    // Reset during RUN, then a clean blinker frame
    load_seed(3, SEED_A, 1'b0);
    repeat (3) step();
    pulse_rst(3, "rst_run");
    run_frame(1, BLINK_V, BLINK_H, 1'b0, 0);
    run_frame(3, BLOCK,   BLOCK,   1'b0, 0);

    // Reset during SEND after three rows, then a clean blinker frame
    load_seed(1, BLINK_V, 1'b0);
    wait_result(1, BLINK_V);
    recv(1, BLINK_H, 3, 1);
    pulse_rst(1, "rst_send");
    run_frame(1, BLINK_V, BLINK_H, 1'b0, 0);

    // Random seeds on random pairs against the reference model
    repeat (12) begin
      idx  = $urandom_range(0, NI - 1);
      seed = {$urandom, $urandom};
      run_frame(idx, seed, life_n(seed, gens_of(idx)), 1'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
